sram_wb_mentor: RTL and testbench

//  Wishbone classic (non-pipelined) mentor/initiator for the sram_1Mx8 responder.

---
 rtl/sram_wb_mentor.sv | 168 ++++++++++++++++
 tb/tb_sram_wb_mentor.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wb_mentor.sv
// -----------------------------------------------------------------------------
// sram_wb_mentor
//   Wishbone classic (non-pipelined) initiator for the sram_1Mx8 responder.
//   Accepts one command at a time on a valid/ready port, runs it as a
//   CYC/STB/WE bus cycle, and returns exactly one response pulse per command.
//   RTY_I makes it drop the strobe for one cycle and try again, up to
//   MAX_RETRIES times. A per-attempt timeout guards against a silent responder.
//
// Command handshake:
//   A command transfers on a rising clk edge where i_cmd_valid & o_cmd_ready
//   are both high. o_cmd_ready is high only in IDLE (and not during reset),
//   so i_cmd_* are ignored while a command is in flight. The response is a
//   single-cycle o_rsp_valid pulse with no back-pressure; a new command may
//   transfer in the same cycle the pulse is high.
//
// Ports:
//   i_clk, i_n_reset      clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_write, i_cmd_addr, i_cmd_data
//                         command port
//   o_rsp_valid, o_rsp_data, o_rsp_err, o_rsp_timeout
//                         response port (o_rsp_data holds the last good read)
//   CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, LOCK_O, DAT_I, ACK_I, ERR_I, RTY_I
//                         Wishbone initiator side
//   dbg_state             current FSM state (IDLE=0, BUS=1, GAP=2)
// -----------------------------------------------------------------------------
module sram_wb_mentor #(
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                  i_clk,
  input  logic                  i_n_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_rsp_timeout,
  output logic                  CYC_O,
  output logic                  STB_O,
  output logic                  WE_O,
  output logic [ADDR_WIDTH-1:0] ADR_O,
  output logic [DATA_WIDTH-1:0] DAT_O,
  output logic                  SEL_O,
  output logic                  LOCK_O,
  input  logic [DATA_WIDTH-1:0] DAT_I,
  input  logic                  ACK_I,
  input  logic                  ERR_I,
  input  logic                  RTY_I,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Counter widths sized so the terminal values always fit.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  state_t          state;
  logic [TW-1:0]   tmo_cnt;
  logic [RW-1:0]   retry_cnt;

  assign o_cmd_ready = (state == S_IDLE) & i_n_reset;
  assign SEL_O       = 1'b1;
  assign LOCK_O      = 1'b0;
  assign dbg_state   = state;

  always_ff @(posedge i_clk) begin
    if (!i_n_reset) begin
      state         <= S_IDLE;
      CYC_O         <= 1'b0;
      STB_O         <= 1'b0;
      WE_O          <= 1'b0;
      ADR_O         <= '0;
      DAT_O         <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
      o_rsp_data    <= '0;
      tmo_cnt       <= '0;
      retry_cnt     <= '0;
    end else begin
      // Response flags are pulses: cleared every cycle unless set below.
      o_rsp_valid   <= 1'b0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            WE_O      <= i_cmd_write;
            ADR_O     <= i_cmd_addr;
            DAT_O     <= i_cmd_data;
            CYC_O     <= 1'b1;
            STB_O     <= 1'b1;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            state     <= S_BUS;
          end
        end

        S_BUS: begin
          // Termination priority: ERR > ACK > RTY > local timeout.
          if (ERR_I) begin
            CYC_O       <= 1'b0;
            STB_O       <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            state       <= S_IDLE;
          end else if (ACK_I) begin
            CYC_O       <= 1'b0;
            STB_O       <= 1'b0;
            o_rsp_valid <= 1'b1;
            if (!WE_O) begin
              o_rsp_data <= DAT_I;
            end
            state       <= S_IDLE;
          end else if (RTY_I) begin
            CYC_O <= 1'b0;
            STB_O <= 1'b0;
            if (retry_cnt == RETRY_MAX) begin
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              state       <= S_IDLE;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_GAP;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            CYC_O         <= 1'b0;
            STB_O         <= 1'b0;
            o_rsp_valid   <= 1'b1;
            o_rsp_err     <= 1'b1;
            o_rsp_timeout <= 1'b1;
            state         <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_GAP: begin
          // One idle bus cycle between attempts; address/data/WE stay put.
          tmo_cnt <= '0;
          CYC_O   <= 1'b1;
          STB_O   <= 1'b1;
          state   <= S_BUS;
        end

        default: begin
          CYC_O <= 1'b0;
          STB_O <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_wb_mentor.sv
module tb_sram_wb_mentor;
  localparam int AW  = 20;
  localparam int DW  = 8;
  localparam int TMO = 15;
  localparam int MR  = 3;

  localparam logic [1:0] K_ACK  = 2'd0;
  localparam logic [1:0] K_ERR  = 2'd1;
  localparam logic [1:0] K_RTY  = 2'd2;
  localparam logic [1:0] K_NONE = 2'd3;

  logic          i_clk;
  logic          i_n_reset;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_write;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_data;
  logic          o_rsp_valid;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_err;
  logic          o_rsp_timeout;
  logic          CYC_O, STB_O, WE_O;
  logic [AW-1:0] ADR_O;
  logic [DW-1:0] DAT_O;
  logic          SEL_O, LOCK_O;
  logic [DW-1:0] DAT_I;
  logic          ACK_I, ERR_I, RTY_I;
  logic [1:0]    dbg_state;

  sram_wb_mentor #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MR)
  ) dut (
    .i_clk(i_clk), .i_n_reset(i_n_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_rsp_err(o_rsp_err), .o_rsp_timeout(o_rsp_timeout),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .SEL_O(SEL_O), .LOCK_O(LOCK_O), .DAT_I(DAT_I),
    .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW+1:0] exp_q[$];   // {err, timeout, rsp_data} per command
  logic [DW-1:0] model_data; // last successfully read byte

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- responder plan ----------------
  logic [3:0][1:0] plan_k;
  logic [3:0][3:0] plan_d;
  logic [DW-1:0]   plan_rd;
  int              plan_id = 0;

  // Per attempt: respond with plan_k after plan_d strobe-high cycles.
  int seen_id = 0;
  int att_idx = 0;
  int stb_age = 0;
  always @(negedge i_clk) begin
    ACK_I = 1'b0;
    ERR_I = 1'b0;
    RTY_I = 1'b0;
    DAT_I = DW'($urandom);
    if (plan_id != seen_id) begin
      seen_id = plan_id;
      att_idx = 0;
      stb_age = 0;
    end
    if (STB_O === 1'b1) begin
      stb_age++;
      if (att_idx < 4 && plan_k[att_idx] != K_NONE && stb_age == int'(plan_d[att_idx])) begin
        case (plan_k[att_idx])
          K_ACK: begin ACK_I = 1'b1; DAT_I = plan_rd; end
          K_ERR: ERR_I = 1'b1;
          K_RTY: RTY_I = 1'b1;
          default: ;
        endcase
      end
    end else if (stb_age != 0) begin
      att_idx++;
      stb_age = 0;
    end
  end

  // ---------------- response protocol monitor ----------------
  logic mon_en  = 1'b0;
  logic prev_rv = 1'b0;
  always @(negedge i_clk) begin
    if (mon_en && i_n_reset) begin
      if (prev_rv) chk("rsp pulse width", 32'(o_rsp_valid), 32'd0);
      if (!o_rsp_valid) chk("flags idle", 32'({o_rsp_err, o_rsp_timeout}), 32'd0);
      prev_rv = o_rsp_valid;
    end else begin
      prev_rv = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // Walk the attempt list with the protocol rules: count strobe cycles,
  // gap cycles, and the response cycle.
  task automatic model(input logic [3:0][1:0] k, input logic [3:0][3:0] d,
                       output logic err, output logic tmo, output int lat, output int stb);
    int retries;
    retries = 0; lat = 0; stb = 0; err = 1'b0; tmo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (k[i] == K_NONE) begin
        stb += TMO; lat += TMO; err = 1'b1; tmo = 1'b1;
        break;
      end
      stb += int'(d[i]);
      lat += int'(d[i]);
      if (k[i] == K_ERR) begin err = 1'b1; break; end
      if (k[i] == K_ACK) break;
      if (retries == MR) begin err = 1'b1; break; end
      retries++;
      lat += 1;
    end
    lat += 1;
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle (or in its response cycle).
  task automatic run_cmd(input string tag, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] rd,
                         input logic [3:0][1:0] k, input logic [3:0][3:0] dl,
                         input logic e_err, input logic e_tmo, input logic [DW-1:0] e_data,
                         input int e_lat, input int e_stb);
    int lat, stb;
    logic got;
    logic [DW+1:0] exp_w;
    exp_q.push_back({e_err, e_tmo, e_data});
    chk({tag, " ready"}, 32'(o_cmd_ready), 32'd1);
    plan_k = k; plan_d = dl; plan_rd = rd; plan_id++;
    i_cmd_valid = 1'b1; i_cmd_write = w; i_cmd_addr = a; i_cmd_data = d;
    @(posedge i_clk); #1;
    // Junk on the command port while busy must be ignored.
    i_cmd_valid = 1'b0;
    i_cmd_write = 1'($urandom);
    i_cmd_addr  = AW'($urandom);
    i_cmd_data  = DW'($urandom);
    lat = 0; stb = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge i_clk);
      lat++;
      if (lat == 1) begin
        chk({tag, " stb first"}, 32'({CYC_O, STB_O}), 32'd3);
        chk({tag, " bus addr"}, 32'(ADR_O), 32'(a));
        chk({tag, " bus we/dat"}, 32'({WE_O, DAT_O}), 32'({w, d}));
      end
      if (STB_O) stb++;
      if (o_rsp_valid) got = 1'b1;
    end
    chk({tag, " rsp seen"}, 32'(got), 32'd1);
    exp_w = exp_q.pop_front();
    if (got) begin
      chk({tag, " rsp err/tmo/data"}, 32'({o_rsp_err, o_rsp_timeout, o_rsp_data}), 32'(exp_w));
      chk({tag, " latency"}, 32'(lat), 32'(e_lat));
      chk({tag, " stb cycles"}, 32'(stb), 32'(e_stb));
      chk({tag, " bus idle at rsp"}, 32'({CYC_O, STB_O}), 32'd0);
      chk({tag, " bus held"}, 32'({WE_O, DAT_O, ADR_O}), 32'({w, d, a}));
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct packed {
    logic            w;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic [DW-1:0]   rd;
    logic [3:0][1:0] k;
    logic [3:0][3:0] dl;
    logic            e_err;
    logic            e_tmo;
    logic [DW-1:0]   e_data;
    logic [7:0]      e_lat;
    logic [7:0]      e_stb;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [DW-1:0] rd,
                              input logic [1:0] k0, input logic [3:0] d0,
                              input logic [1:0] k1, input logic [3:0] d1,
                              input logic [1:0] k2, input logic [3:0] d2,
                              input logic [1:0] k3, input logic [3:0] d3,
                              input logic e_err, input logic e_tmo, input logic [DW-1:0] e_data,
                              input logic [7:0] e_lat, input logic [7:0] e_stb);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.rd = rd;
    v.k  = {k3, k2, k1, k0};
    v.dl = {d3, d2, d1, d0};
    v.e_err = e_err; v.e_tmo = e_tmo; v.e_data = e_data;
    v.e_lat = e_lat; v.e_stb = e_stb;
    return v;
  endfunction

  vec_t tbl[10];

  function automatic logic [1:0] rand_kind();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return K_ACK;
    if (r == 5) return K_ERR;
    if (r < 9) return K_RTY;
    return K_NONE;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0][1:0] rk;
    logic [3:0][3:0] rdl;
    logic            m_err, m_tmo, rw;
    logic [AW-1:0]   ra;
    logic [DW-1:0]   rdat, rrd;
    int              m_lat, m_stb;

    //       w     addr        d      rd     k0     d0  k1     d1  k2     d2  k3      d3  err   tmo   data   lat stb
    tbl[0] = mk(1'b1, 20'd1777, 8'hC9, 8'h00, K_ACK, 2, K_ACK, 1, K_ACK, 1, K_ACK,  1, 1'b0, 1'b0, 8'h00,  3,  2);
    tbl[1] = mk(1'b0, 20'd1777, 8'h00, 8'hC9, K_ACK, 1, K_ACK, 1, K_ACK, 1, K_ACK,  1, 1'b0, 1'b0, 8'hC9,  2,  1);
    tbl[2] = mk(1'b1, 20'd1778, 8'h5A, 8'hEE, K_ACK, 1, K_ACK, 1, K_ACK, 1, K_ACK,  1, 1'b0, 1'b0, 8'hC9,  2,  1);
    tbl[3] = mk(1'b0, 20'd5,    8'h00, 8'h3C, K_RTY, 1, K_RTY, 1, K_ACK, 1, K_ACK,  1, 1'b0, 1'b0, 8'h3C,  6,  3);
    tbl[4] = mk(1'b0, 20'd6,    8'h00, 8'h77, K_RTY, 1, K_RTY, 1, K_RTY, 1, K_RTY,  1, 1'b1, 1'b0, 8'h3C,  8,  4);
    tbl[5] = mk(1'b0, 20'd7,    8'h00, 8'h11, K_NONE,1, K_ACK, 1, K_ACK, 1, K_ACK,  1, 1'b1, 1'b1, 8'h3C, 16, 15);
    tbl[6] = mk(1'b0, 20'd8,    8'h00, 8'h22, K_ERR, 3, K_ACK, 1, K_ACK, 1, K_ACK,  1, 1'b1, 1'b0, 8'h3C,  4,  3);
    tbl[7] = mk(1'b0, 20'd9,    8'h00, 8'h33, K_RTY, 2, K_ERR, 1, K_ACK, 1, K_ACK,  1, 1'b1, 1'b0, 8'h3C,  5,  3);
    tbl[8] = mk(1'b0, 20'hFFFFF,8'h00, 8'hA5, K_ACK, 1, K_ACK, 1, K_ACK, 1, K_ACK,  1, 1'b0, 1'b0, 8'hA5,  2,  1);
    tbl[9] = mk(1'b1, 20'd0,    8'hFF, 8'h44, K_RTY, 1, K_NONE,1, K_ACK, 1, K_ACK,  1, 1'b1, 1'b1, 8'hA5, 18, 16);

    plan_k = '1; plan_d = '0; plan_rd = '0;
    i_n_reset = 1'b0;
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b1;
    i_cmd_addr = 20'd123;
    i_cmd_data = 8'h55;

    // Reset held with a command offered: nothing may start.
    repeat (5) begin
      @(negedge i_clk);
      chk("reset bus/rsp", 32'({CYC_O, STB_O, o_rsp_valid}), 32'd0);
      chk("reset ready", 32'(o_cmd_ready), 32'd0);
    end
    chk("reset regs", 32'({WE_O, ADR_O, DAT_O, o_rsp_data, o_rsp_err, o_rsp_timeout}), 32'd0);
    i_cmd_valid = 1'b0;
    i_n_reset = 1'b1;
    mon_en = 1'b1;
    @(negedge i_clk);
    chk("post reset ready", 32'(o_cmd_ready), 32'd1);
    chk("post reset idle", 32'({CYC_O, STB_O, o_rsp_valid}), 32'd0);
    chk("sel/lock", 32'({SEL_O, LOCK_O}), 32'd2);

    // Table vectors, run back-to-back (each accepted in the previous rsp cycle).
    model_data = 8'h00;
    for (int i = 0; i < 10; i++) begin
      run_cmd($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rd,
              tbl[i].k, tbl[i].dl, tbl[i].e_err, tbl[i].e_tmo, tbl[i].e_data,
              int'(tbl[i].e_lat), int'(tbl[i].e_stb));
    end
    model_data = 8'hA5;

    // Reset pulse while the strobe is up: command is dropped silently.
    @(negedge i_clk);
    plan_k = '1; plan_id++;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 20'd42; i_cmd_data = 8'h00;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("mid-reset stb up", 32'({CYC_O, STB_O}), 32'd3);
    i_n_reset = 1'b0;
    @(negedge i_clk);
    chk("mid-reset bus low", 32'({CYC_O, STB_O}), 32'd0);
    chk("mid-reset no rsp", 32'(o_rsp_valid), 32'd0);
    chk("mid-reset ready", 32'(o_cmd_ready), 32'd0);
    chk("mid-reset regs", 32'({ADR_O, o_rsp_data}), 32'd0);
    i_n_reset = 1'b1;
    @(negedge i_clk);
    chk("after release ready", 32'(o_cmd_ready), 32'd1);
    repeat (20) begin
      @(negedge i_clk);
      chk("after release quiet", 32'({o_rsp_valid, STB_O}), 32'd0);
    end
    model_data = 8'h00;

    // Randomized commands against the reference model.
    for (int n = 0; n < 60; n++) begin
      rw = 1'($urandom);
      ra = AW'($urandom);
      rdat = DW'($urandom);
      rrd = DW'($urandom);
      for (int j = 0; j < 4; j++) begin
        rk[j]  = rand_kind();
        rdl[j] = 4'($urandom_range(1, 4));
      end
      model(rk, rdl, m_err, m_tmo, m_lat, m_stb);
      if (!rw && !m_err) model_data = rrd;
      run_cmd($sformatf("rnd%0d", n), rw, ra, rdat, rrd, rk, rdl,
              m_err, m_tmo, model_data, m_lat, m_stb);
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end

    @(negedge i_clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
